norm_frame_assembler: RTL and testbench
=======================================

# norm_frame_assembler

Upstream companion of the `Normalize` stage. It accepts a stream of raw signed glove-sensor samples in channel order and applies per-channel mean/std coefficients through an internal `Normalize` instance. It packs the normalized Q8.8 results into one frame per sensor sweep and hands complete frames to the classifier with a valid/ready handshake.

## Interface
- `CH`, default 6: channels per frame (2..16).
- `DW`, default 16: sample, coefficient and normalized word width; fixed at 16 for `Normalize`.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: reset, asynchronous and active-high.
- `i_clear`  in  1: synchronous flush of the partial frame; coefficients are kept.
- `i_cfg_we`  in  1: coefficient write strobe.
- `i_cfg_sel`  in  1: 0 = mean, 1 = std.
- `i_cfg_addr`  in  $clog2(CH): channel index for the coefficient write.
- `i_cfg_data`  in  DW: coefficient value; mean is signed, std is unsigned.
- `i_valid`  in  1: raw sample valid.
- `o_ready`  out  1: block can accept a sample.
- `i_data`  in  DW: raw signed sample.
- `o_frame_valid`  out  1: output frame valid.
- `i_frame_ready`  in  1: consumer accepts the frame.
- `o_frame`  out  CH*DW: normalized frame; channel c occupies bits [c*DW +: DW].
- `o_frame_cnt`  out  16: count of frames delivered; wraps modulo 2^16.

## Operation
- Coefficient tables: `mean[CH]` and `std[CH]`.
  - Reset values: mean = 0, std = 1.
  - Write on the edge where `i_cfg_we` = 1. An out-of-range address (≥ CH) is ignored.
  - A write to std with value 0 stores 1, so `Normalize` never sees a zero divisor.
- Sample acceptance:
  - A sample is accepted on an edge where `i_valid && o_ready`.
  - The channel index `idx` (reset 0) selects the coefficients. `Normalize` is driven combinationally with `i_data`, `mean[idx]` and `std[idx]`.
  - Its `o_norm` (Q8.8, quotient truncated toward zero) is written into `asm[idx]`, and `idx` increments.
- Frame completion:
  - Accepting channel CH-1 wraps `idx` to 0 and sets `asm_full`.
  - `o_ready = !asm_full`.
- Frame transfer:
  - Condition: `asm_full && (!o_frame_valid || i_frame_ready)`.
  - On that edge, `asm` is copied to the output register, `o_frame_valid` is set, `asm_full` is cleared, and `o_frame_cnt` increments.
- Frame delivery:
  - Transfer handshake: `o_frame_valid && i_frame_ready`. If no new transfer occurs on the same edge, `o_frame_valid` clears.
  - A same-edge transfer keeps `o_frame_valid` high and loads the new frame.
  - `o_frame` holds stable while `o_frame_valid` is high and `i_frame_ready` is low.
- `i_clear`:
  - Sets `idx` to 0 and clears `asm_full`. Any sample offered in the same cycle is dropped.
  - Does not affect the output register, `o_frame_valid` or `o_frame_cnt`.
- Coefficient write to the channel being accepted in the same cycle: the sample uses the old value.
- Effective states: FILL (`!asm_full`), HOLD (`asm_full`, output busy). Output register: EMPTY/VALID.

## Timing
- Reset values: `o_ready` = 1, `o_frame_valid` = 0, `o_frame` = 0, `o_frame_cnt` = 0, `idx` = 0, `asm_full` = 0.
- Normalization is combinational within the accept cycle. One register stage goes into `asm`.
- Latency from the edge accepting the last sample (k) to `o_frame_valid` high: 1 edge, so it is visible after edge k+1.
  - `o_ready` is low for exactly the cycle between k and k+1 when the output is free.
  - It stays low for longer while the consumer stalls.
- Maximum throughput is one frame per CH+1 cycles.
- Backpressure never drops samples.
  - The only loss path is `i_clear`.
  - Reset mid-frame discards `asm` and the output frame immediately (asynchronous).

## Test plan
- Worked example:
  - Stimulus: CH=6 with channel 0 configured mean = 7, std = 3 and other channels left at reset values; feed samples -69, 100, 0, -1, 256, 32767.
  - Response: channel 0 = 0xE6AB (-76·256/3 = -6485.33 → -6485), channel 1 = 0x6400, channel 2 = 0x0000, channel 3 = 0xFF00.
  - `o_frame_valid` rises one edge after the 6th accept, and `o_frame_cnt` = 1.
- Zero std:
  - Stimulus: write std = 0 to channel 2, then send 5.
  - Response: std reads as 1 and channel 2 = 0x0500.
- Backpressure:
  - Stimulus: hold `i_frame_ready` = 0 and stream 3 frames continuously.
  - Response: frame 1 is held stable and frame 2 fills `asm` with `o_ready` = 0 afterward. No sample is lost.
  - After releasing ready, frames are delivered in order and `o_frame_cnt` = 3.
- Back-to-back transfer:
  - Stimulus: keep `i_frame_ready` = 1 while `asm` completes.
  - Response: `o_frame_valid` stays high across the handover, the new data appears, and the count increments once per frame.
- Flush:
  - Stimulus: 3 samples, `i_clear`, then 6 samples.
  - Response: the frame contains only the last 6 samples, with the first of them in channel 0.
- Async reset:
  - Stimulus: assert `i_rst` between clock edges mid-frame and while `o_frame_valid` = 1.
  - Response: outputs take reset values immediately, and the next sample lands in channel 0.

Source files
------------

// File: rtl/norm_frame_assembler_if.sv
// Bundle of the sample, coefficient and frame-output signals of norm_frame_assembler.
// The master modport drives the samples and coefficients; the slave modport is the assembler.
interface norm_frame_assembler_if #(
  parameter int CH = 6,
  parameter int DW = 16
);
  localparam int AW = (CH > 1) ? $clog2(CH) : 1;

  logic              i_clear;
  logic              i_cfg_we;
  logic              i_cfg_sel;
  logic [AW-1:0]     i_cfg_addr;
  logic [DW-1:0]     i_cfg_data;
  logic              i_valid;
  logic              o_ready;
  logic [DW-1:0]     i_data;
  logic              o_frame_valid;
  logic              i_frame_ready;
  logic [CH*DW-1:0]  o_frame;
  logic [15:0]       o_frame_cnt;

  modport master (
    output i_clear, i_cfg_we, i_cfg_sel, i_cfg_addr, i_cfg_data,
    output i_valid, i_data, i_frame_ready,
    input  o_ready, o_frame_valid, o_frame, o_frame_cnt
  );

  modport slave (
    input  i_clear, i_cfg_we, i_cfg_sel, i_cfg_addr, i_cfg_data,
    input  i_valid, i_data, i_frame_ready,
    output o_ready, o_frame_valid, o_frame, o_frame_cnt
  );
endinterface

// File: rtl/norm_frame_assembler.sv
// Normalizes raw glove samples per channel and packs one Q8.8 frame per sensor sweep.
// Normalize computes (x - mean) * 256 / std, truncated toward zero and saturated to 16 bits.
module Normalize (
  input  logic signed [15:0] i_x,
  input  logic signed [15:0] i_mean,
  input  logic        [15:0] i_std,
  output logic signed [15:0] o_norm
);
  logic signed [16:0] w_diff;
  logic signed [25:0] w_num;
  logic signed [25:0] w_den;
  logic signed [25:0] w_quot;

  always_comb begin
    w_diff = {i_x[15], i_x} - {i_mean[15], i_mean};
    w_num  = {w_diff[16], w_diff, 8'd0};
    w_den  = {10'd0, i_std};
    w_quot = w_num / w_den;
    if (w_quot > 26'sd32767) begin
      o_norm = 16'sh7FFF;
    end else if (w_quot < -26'sd32768) begin
      o_norm = -16'sd32768;
    end else begin
      o_norm = w_quot[15:0];
    end
  end
endmodule

module norm_frame_assembler #(
  parameter int CH = 6,
  parameter int DW = 16
) (
  input logic i_clk,
  input logic i_rst,
  norm_frame_assembler_if.slave bus
);
  localparam int AW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {FILL, HOLD} asm_state_t;

  asm_state_t        r_state;
  logic [AW-1:0]     r_idx;
  logic [DW-1:0]     r_mean [CH];
  logic [DW-1:0]     r_std  [CH];
  logic [DW-1:0]     r_asm  [CH];
  logic [CH*DW-1:0]  r_frame;
  logic              r_frameValid;
  logic [15:0]       r_frameCnt;

  logic [DW-1:0]     w_norm;
  logic              w_accept;
  logic              w_xfer;

  Normalize u_norm (
    .i_x    (bus.i_data),
    .i_mean (r_mean[r_idx]),
    .i_std  (r_std[r_idx]),
    .o_norm (w_norm)
  );

  // A flush in the same cycle drops the offered sample.
  assign w_accept = bus.i_valid && (r_state == FILL) && !bus.i_clear;
  assign w_xfer   = (r_state == HOLD) && (!r_frameValid || bus.i_frame_ready);

  assign bus.o_ready       = (r_state == FILL);
  assign bus.o_frame_valid = r_frameValid;
  assign bus.o_frame       = r_frame;
  assign bus.o_frame_cnt   = r_frameCnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= FILL;
      r_idx        <= '0;
      r_frame      <= '0;
      r_frameValid <= 1'b0;
      r_frameCnt   <= '0;
      for (int c = 0; c < CH; c++) begin
        r_mean[c] <= '0;
        r_std[c]  <= DW'(1);
        r_asm[c]  <= '0;
      end
    end else begin
      // A zero std is stored as 1 so the divider never sees zero.
      if (bus.i_cfg_we && (32'(bus.i_cfg_addr) < CH)) begin
        if (bus.i_cfg_sel) begin
          r_std[bus.i_cfg_addr] <= (bus.i_cfg_data == '0) ? DW'(1) : bus.i_cfg_data;
        end else begin
          r_mean[bus.i_cfg_addr] <= bus.i_cfg_data;
        end
      end

      if (w_accept) begin
        r_asm[r_idx] <= w_norm;
        if (r_idx == AW'(CH - 1)) begin
          r_idx   <= '0;
          r_state <= HOLD;
        end else begin
          r_idx <= r_idx + AW'(1);
        end
      end

      if (w_xfer) begin
        for (int c = 0; c < CH; c++) begin
          r_frame[c*DW +: DW] <= r_asm[c];
        end
        r_frameValid <= 1'b1;
        r_frameCnt   <= r_frameCnt + 16'd1;
        r_state      <= FILL;
      end else if (r_frameValid && bus.i_frame_ready) begin
        r_frameValid <= 1'b0;
      end

      if (bus.i_clear) begin
        r_idx   <= '0;
        r_state <= FILL;
      end
    end
  end
endmodule

// File: tb/tb_norm_frame_assembler.sv
// Directed self-checking bench for norm_frame_assembler (CH = 6, DW = 16).
// Expected frames are hand-computed Q8.8 values of (x - mean) * 256 / std.
module tb_norm_frame_assembler;
  localparam int CH = 6;
  localparam int DW = 16;
  localparam int FW = CH * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  norm_frame_assembler_if #(.CH(CH), .DW(DW)) bus ();

  norm_frame_assembler #(.CH(CH), .DW(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [FW-1:0] observed,
                             input logic [FW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers one sample, waiting (bounded) for o_ready, and returns right after the accepting edge.
  task automatic applyStimulus(input logic [15:0] d);
    int waitCnt;
    waitCnt = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    while (!bus.o_ready && waitCnt < 40) begin
      tick();
      waitCnt++;
    end
    if (waitCnt >= 40) checkOutput("acceptTimeout", FW'(bus.o_ready), FW'(1));
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic writeCfg(input logic sel, input logic [2:0] addr, input logic [15:0] data);
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_sel  = sel;
    bus.i_cfg_addr = addr;
    bus.i_cfg_data = data;
    tick();
    bus.i_cfg_we = 1'b0;
  endtask

  function automatic logic [FW-1:0] packFrame(input logic [15:0] c0, input logic [15:0] c1,
                                              input logic [15:0] c2, input logic [15:0] c3,
                                              input logic [15:0] c4, input logic [15:0] c5);
    return {c5, c4, c3, c2, c1, c0};
  endfunction

  initial begin
    bus.i_clear       = 1'b0;
    bus.i_cfg_we      = 1'b0;
    bus.i_cfg_sel     = 1'b0;
    bus.i_cfg_addr    = '0;
    bus.i_cfg_data    = '0;
    bus.i_valid       = 1'b0;
    bus.i_data        = '0;
    bus.i_frame_ready = 1'b0;

    tick();
    tick();
    checkOutput("rstReady", FW'(bus.o_ready), FW'(1));
    checkOutput("rstValid", FW'(bus.o_frame_valid), FW'(0));
    checkOutput("rstFrame", bus.o_frame, '0);
    checkOutput("rstCnt", FW'(bus.o_frame_cnt), FW'(0));
    rst = 1'b0;
    tick();

    // Worked example: channel 0 mean 7, std 3.
    writeCfg(1'b0, 3'd0, 16'd7);
    writeCfg(1'b1, 3'd0, 16'd3);
    applyStimulus(-16'sd69);
    applyStimulus(16'd100);
    applyStimulus(16'd0);
    applyStimulus(-16'sd1);
    applyStimulus(16'd256);
    applyStimulus(16'd32767);
    checkOutput("exReadyLow", FW'(bus.o_ready), FW'(0));
    checkOutput("exValidLate", FW'(bus.o_frame_valid), FW'(0));
    tick();
    checkOutput("exValid", FW'(bus.o_frame_valid), FW'(1));
    checkOutput("exFrame", FW'(bus.o_frame[63:0]), FW'(64'hFF00_0000_6400_E6AB));
    checkOutput("exCnt", FW'(bus.o_frame_cnt), FW'(1));
    checkOutput("exReadyBack", FW'(bus.o_ready), FW'(1));
    bus.i_frame_ready = 1'b1;
    tick();
    checkOutput("exDelivered", FW'(bus.o_frame_valid), FW'(0));

    // Zero std on channel 2 is stored as 1.
    bus.i_frame_ready = 1'b0;
    writeCfg(1'b1, 3'd2, 16'd0);
    applyStimulus(16'd1);
    applyStimulus(16'd2);
    applyStimulus(16'd5);
    applyStimulus(16'd3);
    applyStimulus(16'd4);
    applyStimulus(-16'sd2);
    tick();
    checkOutput("zsValid", FW'(bus.o_frame_valid), FW'(1));
    checkOutput("zsFrame", bus.o_frame,
                packFrame(16'hFE00, 16'h0200, 16'h0500, 16'h0300, 16'h0400, 16'hFE00));
    checkOutput("zsCnt", FW'(bus.o_frame_cnt), FW'(2));

    // Async reset between edges, mid-frame and with a valid output frame.
    applyStimulus(16'd11);
    applyStimulus(16'd12);
    applyStimulus(16'd13);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arValid", FW'(bus.o_frame_valid), FW'(0));
    checkOutput("arFrame", bus.o_frame, '0);
    checkOutput("arCnt", FW'(bus.o_frame_cnt), FW'(0));
    checkOutput("arReady", FW'(bus.o_ready), FW'(1));
    #1;
    rst = 1'b0;
    tick();

    // Backpressure: consumer stalled while frames 1 and 2 stream in.
    applyStimulus(16'd10);
    applyStimulus(16'd20);
    applyStimulus(16'd30);
    applyStimulus(16'd40);
    applyStimulus(16'd50);
    applyStimulus(16'd60);
    applyStimulus(-16'sd1);
    applyStimulus(-16'sd2);
    applyStimulus(-16'sd3);
    applyStimulus(-16'sd4);
    applyStimulus(-16'sd5);
    applyStimulus(-16'sd6);
    tick();
    tick();
    checkOutput("bpFrame1", bus.o_frame,
                packFrame(16'h0A00, 16'h1400, 16'h1E00, 16'h2800, 16'h3200, 16'h3C00));
    checkOutput("bpValid1", FW'(bus.o_frame_valid), FW'(1));
    checkOutput("bpReadyLow", FW'(bus.o_ready), FW'(0));
    checkOutput("bpCnt1", FW'(bus.o_frame_cnt), FW'(1));
    bus.i_frame_ready = 1'b1;
    tick();
    checkOutput("b2bValid", FW'(bus.o_frame_valid), FW'(1));
    checkOutput("b2bFrame2", bus.o_frame,
                packFrame(16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00, 16'hFB00, 16'hFA00));
    checkOutput("b2bCnt2", FW'(bus.o_frame_cnt), FW'(2));
    checkOutput("b2bReady", FW'(bus.o_ready), FW'(1));
    bus.i_frame_ready = 1'b0;
    applyStimulus(16'd1);
    applyStimulus(16'd2);
    applyStimulus(16'd3);
    applyStimulus(16'd4);
    applyStimulus(16'd5);
    applyStimulus(16'd6);
    tick();
    checkOutput("bpHold2", bus.o_frame,
                packFrame(16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00, 16'hFB00, 16'hFA00));
    checkOutput("bpReadyLow3", FW'(bus.o_ready), FW'(0));
    bus.i_frame_ready = 1'b1;
    tick();
    checkOutput("bpFrame3", bus.o_frame,
                packFrame(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600));
    checkOutput("bpCnt3", FW'(bus.o_frame_cnt), FW'(3));
    tick();
    checkOutput("bpDrained", FW'(bus.o_frame_valid), FW'(0));

    // Flush after 3 samples; the sample offered with i_clear is dropped.
    applyStimulus(16'd7);
    applyStimulus(16'd8);
    applyStimulus(16'd9);
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 16'd99;
    tick();
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_sel  = 1'b0;
    bus.i_cfg_addr = 3'd0;
    bus.i_cfg_data = 16'd256;
    applyStimulus(16'd1);
    bus.i_cfg_we = 1'b0;
    applyStimulus(16'd2);
    applyStimulus(16'd3);
    applyStimulus(16'd4);
    applyStimulus(16'd5);
    applyStimulus(16'd6);
    checkOutput("flReadyLow", FW'(bus.o_ready), FW'(0));
    checkOutput("flValidLate", FW'(bus.o_frame_valid), FW'(0));
    tick();
    checkOutput("flFrame", bus.o_frame,
                packFrame(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600));
    checkOutput("flCnt", FW'(bus.o_frame_cnt), FW'(4));

    // The mean written alongside the first sample applies from the next frame.
    applyStimulus(16'd257);
    applyStimulus(16'd0);
    applyStimulus(16'd0);
    applyStimulus(16'd0);
    applyStimulus(16'd0);
    applyStimulus(16'd0);
    tick();
    checkOutput("cfgNewMean", bus.o_frame,
                packFrame(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    checkOutput("cfgCnt", FW'(bus.o_frame_cnt), FW'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
